// File: rtl/led_switch_io_if.sv
// led_switch_io_if: CPU I/O bus between the data-memory/IO mux and the LED/switch responder.
interface led_switch_io_if;
   logic        LEDCtrl;
   logic        SwitchCtrl;
   logic [31:0] addr_in;
   logic [31:0] write_data;
   logic [15:0] io_rdata;
   modport master (output LEDCtrl, SwitchCtrl, addr_in, write_data, input io_rdata);
   modport slave (input LEDCtrl, SwitchCtrl, addr_in, write_data, output io_rdata);
endinterface

// File: rtl/led_switch_io.sv
// led_switch_io: memory-mapped LED register plus synchronised, debounced switch inputs
// with a change flag, returning registered read data to the I/O mux.
module led_switch_io #(
   parameter int          DEBOUNCE_CYCLES = 500000,
   parameter logic [23:0] IO_BASE         = 24'hFFFFFC
) (
   input  logic                  clock,
   input  logic                  reset,
   led_switch_io_if.slave        bus,
   input  logic [15:0]           switch_in,
   output logic [15:0]           led_out,
   output logic                  sw_changed
);
   localparam int            CW   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, COUNT, ACCEPT} db_e;

   db_e           db;
   logic [15:0]   led_q, led_d, rdata_q, rdata_d;
   logic [15:0]   s1_q, s2_q, stable_q, stable_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          chg_q, chg_d;
   logic          hit, rd, rd_sw;
   logic [7:0]    off;
   logic          unused_hi;

   assign unused_hi  = ^bus.write_data[31:16];
   assign led_out    = led_q;
   assign sw_changed = chg_q;
   assign bus.io_rdata = rdata_q;

   always_comb begin
      hit      = bus.addr_in[31:8] == IO_BASE;
      off      = bus.addr_in[7:0];
      rd       = bus.SwitchCtrl && hit;
      rd_sw    = rd && off == 8'h70;
      db       = (s2_q == stable_q) ? IDLE : (cnt_q == LAST ? ACCEPT : COUNT);
      cnt_d    = (db == COUNT) ? cnt_q + 1'b1 : '0;
      stable_d = (db == ACCEPT) ? s2_q : stable_q;
      // a same-edge accept beats the read-to-clear
      chg_d    = (db == ACCEPT) || (chg_q && !rd_sw);
      led_d    = (bus.LEDCtrl && hit && off == 8'h60) ? bus.write_data[15:0] : led_q;
      rdata_d  = !rd           ? 16'h0000 :
                 off == 8'h60  ? led_q :
                 off == 8'h70  ? stable_q :
                 off == 8'h74  ? {15'b0, chg_q} : 16'h0000;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         led_q    <= '0;
         rdata_q  <= '0;
         s1_q     <= '0;
         s2_q     <= '0;
         stable_q <= '0;
         cnt_q    <= '0;
         chg_q    <= 1'b0;
      end else begin
         led_q    <= led_d;
         rdata_q  <= rdata_d;
         s1_q     <= switch_in;
         s2_q     <= s1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         chg_q    <= chg_d;
      end
   end
endmodule

// File: tb/tb_led_switch_io.sv
// tb_led_switch_io: scenario tasks plus randomized traffic against a run-length debounce model.
module tb_led_switch_io;
   localparam int D = 4;
   localparam logic [31:0] A_LED = 32'hFFFFFC60, A_SW = 32'hFFFFFC70, A_ST = 32'hFFFFFC74;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] switch_in = '0;
   logic [15:0] led_out;
   logic        sw_changed;
   int          chk = 0, err = 0;

   logic [15:0] m_led, m_rd, m_stable;
   logic        m_chg;
   int          m_run;
   logic [15:0] hist[$];

   led_switch_io_if bus();

   led_switch_io #(.DEBOUNCE_CYCLES(D), .IO_BASE(24'hFFFFFC)) dut (
      .clock(clk), .reset(rst), .bus(bus),
      .switch_in(switch_in), .led_out(led_out), .sw_changed(sw_changed)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic model_reset();
      m_led = 0; m_rd = 0; m_stable = 0; m_chg = 0; m_run = 0;
      hist.delete();
   endtask

   task automatic model_edge();
      logic [15:0] sv;
      logic        h, acc;
      logic [7:0]  o;
      h = bus.addr_in[31:8] == 24'hFFFFFC;
      o = bus.addr_in[7:0];
      m_rd = 16'h0;
      if (bus.SwitchCtrl && h && o == 8'h60) m_rd = m_led;
      if (bus.SwitchCtrl && h && o == 8'h70) m_rd = m_stable;
      if (bus.SwitchCtrl && h && o == 8'h74) m_rd = {15'b0, m_chg};
      sv  = hist.size() > 1 ? hist[1] : 16'h0;
      acc = 1'b0;
      if (sv == m_stable) m_run = 0;
      else begin
         m_run++;
         if (m_run == D) begin m_stable = sv; m_run = 0; acc = 1'b1; end
      end
      if (acc) m_chg = 1'b1;
      else if (bus.SwitchCtrl && h && o == 8'h70) m_chg = 1'b0;
      if (bus.LEDCtrl && h && o == 8'h60) m_led = bus.write_data[15:0];
      hist.push_front(switch_in);
      if (hist.size() > 2) void'(hist.pop_back());
   endtask

   task automatic step(input logic lc, input logic sc, input logic [31:0] a,
                       input logic [31:0] wd, input logic [15:0] sw);
      bus.LEDCtrl = lc; bus.SwitchCtrl = sc; bus.addr_in = a; bus.write_data = wd;
      switch_in = sw;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      bus.LEDCtrl = 0; bus.SwitchCtrl = 0; bus.addr_in = 0; bus.write_data = 0;
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk++; if (led_out !== 16'h0) begin err++; $display("FAIL reset_led got %h want 0000", led_out); end
      chk++; if (bus.io_rdata !== 16'h0) begin err++; $display("FAIL reset_rdata got %h want 0000", bus.io_rdata); end
      chk++; if (sw_changed !== 1'b0) begin err++; $display("FAIL reset_chg got %b want 0", sw_changed); end
      @(posedge clk); @(posedge clk); #1 rst = 1'b0;
   endtask

   task automatic test_led_write();
      step(1, 0, A_LED, 32'h1234ABCD, 16'h0);
      chk++; if (led_out !== 16'hABCD) begin err++; $display("FAIL led_write got %h want abcd", led_out); end
      step(0, 1, A_LED, 32'h0, 16'h0);
      chk++; if (bus.io_rdata !== 16'hABCD) begin err++; $display("FAIL led_read got %h want abcd", bus.io_rdata); end
      step(0, 0, 32'h0, 32'h0, 16'h0);
      chk++; if (bus.io_rdata !== 16'h0) begin err++; $display("FAIL idle_rdata got %h want 0000", bus.io_rdata); end
   endtask

   task automatic test_glitch();
      for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 32'h0, 16'h0001);
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 32'h0, 32'h0, 16'h0000);
         chk++; if (sw_changed !== 1'b0) begin err++; $display("FAIL glitch_chg cyc %0d got %b want 0", i, sw_changed); end
      end
      step(0, 1, A_SW, 32'h0, 16'h0000);
      chk++; if (bus.io_rdata !== 16'h0000) begin err++; $display("FAIL glitch_stable got %h want 0000", bus.io_rdata); end
   endtask

   task automatic test_debounce();
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 32'h0, 32'h0, 16'h00F0);
         chk++; if (sw_changed !== 1'b0) begin err++; $display("FAIL deb_early edge k+%0d got %b want 0", i, sw_changed); end
      end
      step(0, 0, 32'h0, 32'h0, 16'h00F0);
      chk++; if (sw_changed !== 1'b1) begin err++; $display("FAIL deb_accept got %b want 1", sw_changed); end
      step(0, 1, A_ST, 32'h0, 16'h00F0);
      chk++; if (bus.io_rdata !== 16'h0001) begin err++; $display("FAIL deb_status got %h want 0001", bus.io_rdata); end
      step(0, 1, A_SW, 32'h0, 16'h00F0);
      chk++; if (bus.io_rdata !== 16'h00F0) begin err++; $display("FAIL deb_read got %h want 00f0", bus.io_rdata); end
      chk++; if (sw_changed !== 1'b0) begin err++; $display("FAIL deb_clear got %b want 0", sw_changed); end
   endtask

   task automatic test_simultaneous();
      for (int i = 0; i < 5; i++) step(0, 0, 32'h0, 32'h0, 16'h0F0F);
      step(0, 1, A_SW, 32'h0, 16'h0F0F);
      chk++; if (bus.io_rdata !== 16'h00F0) begin err++; $display("FAIL sim_rdata got %h want 00f0", bus.io_rdata); end
      chk++; if (sw_changed !== 1'b1) begin err++; $display("FAIL sim_chg got %b want 1", sw_changed); end
      step(0, 1, A_SW, 32'h0, 16'h0F0F);
      chk++; if (bus.io_rdata !== 16'h0F0F) begin err++; $display("FAIL sim_new got %h want 0f0f", bus.io_rdata); end
   endtask

   task automatic test_decode();
      step(1, 1, A_LED, 32'h0000_5A5A, 16'h0F0F);
      chk++; if (bus.io_rdata !== 16'hABCD) begin err++; $display("FAIL rw_pre got %h want abcd", bus.io_rdata); end
      chk++; if (led_out !== 16'h5A5A) begin err++; $display("FAIL rw_led got %h want 5a5a", led_out); end
      step(0, 1, 32'hFFFFFC64, 32'h0, 16'h0F0F);
      chk++; if (bus.io_rdata !== 16'h0) begin err++; $display("FAIL dec_64 got %h want 0000", bus.io_rdata); end
      step(0, 1, 32'h00000070, 32'h0, 16'h0F0F);
      chk++; if (bus.io_rdata !== 16'h0) begin err++; $display("FAIL dec_base got %h want 0000", bus.io_rdata); end
      step(1, 0, 32'hFFFFFD60, 32'h0000_1111, 16'h0F0F);
      chk++; if (led_out !== 16'h5A5A) begin err++; $display("FAIL dec_write got %h want 5a5a", led_out); end
   endtask

   task automatic test_random();
      logic [31:0] at[6];
      logic [15:0] sw;
      at = '{A_LED, A_SW, A_ST, 32'hFFFFFC64, 32'hFFFFFD70, 32'h00000060};
      sw = switch_in;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 9) == 0) sw = 16'($urandom);
         else if ($urandom_range(0, 14) == 0) sw = sw ^ 16'(1 << $urandom_range(0, 15));
         step($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
              at[$urandom_range(0, 5)], $urandom, sw);
         chk++; if (led_out !== m_led) begin err++; $display("FAIL rnd_led cyc %0d got %h want %h", i, led_out, m_led); end
         chk++; if (bus.io_rdata !== m_rd) begin err++; $display("FAIL rnd_rdata cyc %0d got %h want %h", i, bus.io_rdata, m_rd); end
         chk++; if (sw_changed !== m_chg) begin err++; $display("FAIL rnd_chg cyc %0d got %b want %b", i, sw_changed, m_chg); end
      end
   endtask

   task automatic test_reset_mid();
      step(1, 0, A_LED, 32'h0000_FFFF, 16'h0000);
      for (int i = 0; i < 8; i++) step(0, 1, A_SW, 32'h0, 16'h0000);
      step(0, 0, 32'h0, 32'h0, 16'h8001);
      step(0, 0, 32'h0, 32'h0, 16'h8001);
      step(0, 0, 32'h0, 32'h0, 16'h8001);
      chk++; if (led_out !== 16'hFFFF) begin err++; $display("FAIL mid_pre_led got %h want ffff", led_out); end
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk++; if (led_out !== 16'h0) begin err++; $display("FAIL mid_rst_led got %h want 0000", led_out); end
      chk++; if (bus.io_rdata !== 16'h0) begin err++; $display("FAIL mid_rst_rdata got %h want 0000", bus.io_rdata); end
      chk++; if (sw_changed !== 1'b0) begin err++; $display("FAIL mid_rst_chg got %b want 0", sw_changed); end
      @(posedge clk); @(posedge clk); #2 rst = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         step(0, 0, 32'h0, 32'h0, 16'h8001);
         chk++; if (sw_changed !== 1'b0) begin err++; $display("FAIL rel_early edge %0d got %b want 0", i, sw_changed); end
      end
      step(0, 0, 32'h0, 32'h0, 16'h8001);
      chk++; if (sw_changed !== 1'b1) begin err++; $display("FAIL rel_accept got %b want 1", sw_changed); end
      step(0, 1, A_SW, 32'h0, 16'h8001);
      chk++; if (bus.io_rdata !== 16'h8001) begin err++; $display("FAIL rel_stable got %h want 8001", bus.io_rdata); end
   endtask

   initial begin
      test_reset();
      test_led_write();
      test_glitch();
      test_debounce();
      test_simultaneous();
      test_decode();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", chk, err);
      $finish;
   end
endmodule
